// File: rtl/nand_avalon_csr.sv
// Avalon-MM register front end for the NAND controller.
// Decodes DATA/CMD/STATUS accesses, hands commands to the core, captures
// result bytes, and reports busy/ready/error state plus a completion irq.
module nand_avalon_csr #(
  parameter int DATA_W         = 32,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        addr,
  input  logic              rd,
  input  logic              wr,
  input  logic [DATA_W-1:0] wrdata,
  output logic [DATA_W-1:0] rddata,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [7:0]        cmd_code,
  output logic [7:0]        cmd_data,
  input  logic              core_done,
  input  logic [7:0]        core_rdata,
  input  logic              nand_rnb,
  output logic              irq
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_CMD    = 2'd1;
  localparam logic [1:0] A_STATUS = 2'd2;

  state_t                 state_q;
  logic [7:0]             data_q;
  logic [7:0]             cmd_code_q;
  logic                   cmd_valid_q;
  logic                   irq_q;
  logic                   err_q;
  logic                   tout_q;
  logic [WD_W-1:0]        wd_q;
  logic [SYNC_STAGES-1:0] sync_q;

  logic busy;
  logic rnb_s;
  logic status_rd;
  logic wr_data_reg;
  logic wr_cmd_reg;
  logic err_set_d;
  logic done_set_d;
  logic tout_set_d;
  logic unused_wrdata_hi;

  assign busy        = (state_q != S_IDLE);
  assign rnb_s       = sync_q[SYNC_STAGES-1];
  assign status_rd   = rd && (addr == A_STATUS);
  assign wr_data_reg = wr && (addr == A_DATA);
  assign wr_cmd_reg  = wr && (addr == A_CMD);
  assign err_set_d   = busy && (wr_data_reg || wr_cmd_reg);
  assign done_set_d  = (state_q == S_WAIT) && core_done;
  assign tout_set_d  = (TIMEOUT_CYCLES != 0) && (state_q == S_WAIT) && !core_done
                       && (wd_q == WD_LAST);

  assign unused_wrdata_hi = ^wrdata[DATA_W-1:8];

  assign cmd_valid = cmd_valid_q;
  assign cmd_code  = cmd_code_q;
  assign cmd_data  = data_q;
  assign irq       = irq_q;

  // Zero-wait-state read mux; reads reflect state before any same-cycle write.
  always_comb begin
    rddata = '0;
    if (rd) begin
      case (addr)
        A_DATA:   rddata[7:0] = data_q;
        A_CMD:    rddata[7:0] = cmd_code_q;
        A_STATUS: rddata[3:0] = {tout_q, err_q, rnb_s, busy};
        default:  rddata      = '0;
      endcase
    end
  end

  // Ready/busy pin synchronizer.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], nand_rnb};
    end
  end

  // Command FSM, register file and sticky status flags (set beats STATUS-read clear).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      data_q      <= '0;
      cmd_code_q  <= '0;
      cmd_valid_q <= 1'b0;
      irq_q       <= 1'b0;
      err_q       <= 1'b0;
      tout_q      <= 1'b0;
      wd_q        <= '0;
    end else begin
      if (done_set_d)     irq_q <= 1'b1;
      else if (status_rd) irq_q <= 1'b0;

      if (err_set_d)      err_q <= 1'b1;
      else if (status_rd) err_q <= 1'b0;

      if (tout_set_d)     tout_q <= 1'b1;
      else if (status_rd) tout_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (wr_data_reg) begin
            data_q <= wrdata[7:0];
          end
          if (wr_cmd_reg) begin
            cmd_code_q  <= wrdata[7:0];
            cmd_valid_q <= 1'b1;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (cmd_ready) begin
            cmd_valid_q <= 1'b0;
            wd_q        <= '0;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (core_done) begin
            data_q  <= core_rdata;
            state_q <= S_IDLE;
          end else if (tout_set_d) begin
            state_q <= S_IDLE;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        default: begin
          cmd_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nand_avalon_csr.sv
// Scoreboard bench for nand_avalon_csr: stimulus queues expected read
// responses and command handshakes; a negedge monitor pops and compares.
module tb_nand_avalon_csr;

  localparam int DATA_W = 32;
  localparam int SYNC   = 2;
  localparam int TMO    = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        addr;
  logic              rd;
  logic              wr;
  logic [DATA_W-1:0] wrdata;
  logic [DATA_W-1:0] rddata;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [7:0]        cmd_code;
  logic [7:0]        cmd_data;
  logic              core_done;
  logic [7:0]        core_rdata;
  logic              nand_rnb;
  logic              irq;

  nand_avalon_csr #(
    .DATA_W(DATA_W),
    .SYNC_STAGES(SYNC),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .addr(addr), .rd(rd), .wr(wr), .wrdata(wrdata),
    .rddata(rddata), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_code(cmd_code), .cmd_data(cmd_data), .core_done(core_done),
    .core_rdata(core_rdata), .nand_rnb(nand_rnb), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string             name;
    logic [DATA_W-1:0] rdv;
    logic              irqv;
    logic              cv;
  } rd_exp_t;

  typedef struct {
    logic [7:0]  code;
    logic [7:0]  data;
    int unsigned cycles;
    logic        abort;
  } cmd_exp_t;

  rd_exp_t  rq[$];
  cmd_exp_t cq[$];

  int   checks = 0;
  int   fails  = 0;
  int   vcnt   = 0;
  logic unstable = 1'b0;
  logic end_req  = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input string name, input logic [1:0] a,
                         input logic [7:0] exp_v, input logic exp_irq, input logic exp_cv);
    rd_exp_t e;
    e.name = name; e.rdv = DATA_W'(exp_v); e.irqv = exp_irq; e.cv = exp_cv;
    rq.push_back(e);
    addr = a; rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [7:0] v);
    addr = a; wrdata = DATA_W'(v); wr = 1'b1;
    tick();
    wr = 1'b0;
  endtask

  // Read and write the same register in one cycle; read shows old contents.
  task automatic do_rw(input string name, input logic [1:0] a, input logic [7:0] v,
                       input logic [7:0] exp_old, input logic exp_irq);
    rd_exp_t e;
    e.name = name; e.rdv = DATA_W'(exp_old); e.irqv = exp_irq; e.cv = 1'b0;
    rq.push_back(e);
    addr = a; wrdata = DATA_W'(v); wr = 1'b1; rd = 1'b1;
    tick();
    wr = 1'b0; rd = 1'b0;
  endtask

  task automatic push_cmd(input logic [7:0] c, input logic [7:0] d,
                          input int unsigned n, input logic ab);
    cmd_exp_t e;
    e.code = c; e.data = d; e.cycles = n; e.abort = ab;
    cq.push_back(e);
  endtask

  task automatic done_pulse(input logic [7:0] v);
    core_done = 1'b1; core_rdata = v;
    tick();
    core_done = 1'b0; core_rdata = 8'h00;
  endtask

  // Monitor: read responses, command handshakes, end-of-test accounting.
  always @(negedge clk) begin
    rd_exp_t  re;
    cmd_exp_t ce;
    if (rd) begin
      checks++;
      if (rq.size() == 0) begin
        fails++;
        $display("FAIL unexpected_read: addr=%0d rddata=%h", addr, rddata);
      end else begin
        re = rq.pop_front();
        if (rddata !== re.rdv || irq !== re.irqv || cmd_valid !== re.cv) begin
          fails++;
          $display("FAIL %s: got rddata=%h irq=%b cmd_valid=%b, expected rddata=%h irq=%b cmd_valid=%b",
                   re.name, rddata, irq, cmd_valid, re.rdv, re.irqv, re.cv);
        end
      end
    end

    if (rst) begin
      if (cq.size() != 0 && cq[0].abort) begin
        ce = cq.pop_front();
        checks++;
        if (vcnt == 0 || unstable || cmd_code !== ce.code) begin
          fails++;
          $display("FAIL cmd_abort: valid_cycles=%0d unstable=%b code=%h, expected valid_cycles>0 code=%h",
                   vcnt, unstable, cmd_code, ce.code);
        end
      end
      vcnt = 0; unstable = 1'b0;
    end else if (cmd_valid) begin
      if (cq.size() == 0) begin
        checks++; fails++;
        $display("FAIL unexpected_cmd_valid: code=%h data=%h, expected cmd_valid=0", cmd_code, cmd_data);
      end else begin
        vcnt++;
        if (cmd_code !== cq[0].code || cmd_data !== cq[0].data) unstable = 1'b1;
        if (cmd_ready) begin
          ce = cq.pop_front();
          checks++;
          if (unstable || cmd_code !== ce.code || cmd_data !== ce.data || vcnt != ce.cycles) begin
            fails++;
            $display("FAIL cmd_handshake: code=%h data=%h valid_cycles=%0d unstable=%b, expected code=%h data=%h valid_cycles=%0d",
                     cmd_code, cmd_data, vcnt, unstable, ce.code, ce.data, ce.cycles);
          end
          vcnt = 0; unstable = 1'b0;
        end
      end
    end

    if (end_req) begin
      checks++;
      if (rq.size() != 0 || cq.size() != 0) begin
        fails++;
        $display("FAIL queues_drained: pending reads=%0d cmds=%0d, expected 0 and 0", rq.size(), cq.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, expected end within 100000 time units");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; addr = 2'd0; rd = 1'b0; wr = 1'b0; wrdata = '0;
    cmd_ready = 1'b0; core_done = 1'b0; core_rdata = 8'h00; nand_rnb = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    do_read("rst_status", 2'd2, 8'h00, 1'b0, 1'b0);
    do_read("rst_data",   2'd0, 8'h00, 1'b0, 1'b0);
    do_read("rst_cmd",    2'd1, 8'h00, 1'b0, 1'b0);
    do_read("rst_addr3",  2'd3, 8'h00, 1'b0, 1'b0);

    // Command with immediate ready, completion with result byte
    cmd_ready = 1'b1;
    push_cmd(8'h09, 8'h00, 1, 1'b0);
    do_write(2'd1, 8'h09);
    do_read("a_issue_status", 2'd2, 8'h01, 1'b0, 1'b1);
    do_read("a_wait_status",  2'd2, 8'h01, 1'b0, 1'b0);
    done_pulse(8'hC2);
    do_read("a_done_status",  2'd2, 8'h00, 1'b1, 1'b0);
    do_read("a_data_irqclr",  2'd0, 8'hC2, 1'b0, 1'b0);

    // Operand held through a delayed handshake, writes while busy dropped
    cmd_ready = 1'b0;
    do_write(2'd0, 8'h5A);
    push_cmd(8'h11, 8'h5A, 6, 1'b0);
    do_write(2'd1, 8'h11);
    repeat (5) tick();
    cmd_ready = 1'b1;
    tick();
    do_write(2'd1, 8'h33);
    do_write(2'd0, 8'h77);
    do_read("b_err_status",   2'd2, 8'h05, 1'b0, 1'b0);
    do_read("b_err_cleared",  2'd2, 8'h01, 1'b0, 1'b0);
    do_read("b_cmd_kept",     2'd1, 8'h11, 1'b0, 1'b0);
    done_pulse(8'h3C);
    do_read("b_data_result",  2'd0, 8'h3C, 1'b1, 1'b0);
    do_read("b_status_irq",   2'd2, 8'h00, 1'b1, 1'b0);
    do_read("b_irq_cleared",  2'd0, 8'h3C, 1'b0, 1'b0);
    do_rw("b_rw_old_data",    2'd0, 8'h81, 8'h3C, 1'b0);
    do_read("b_rw_new_data",  2'd0, 8'h81, 1'b0, 1'b0);

    // Watchdog: TMO cycles in WAIT; the read in the last WAIT cycle races the set
    push_cmd(8'h44, 8'h81, 1, 1'b0);
    do_write(2'd1, 8'h44);
    repeat (TMO) tick();
    do_read("c_last_wait",    2'd2, 8'h01, 1'b0, 1'b0);
    do_read("c_tout_set",     2'd2, 8'h08, 1'b0, 1'b0);
    do_read("c_tout_cleared", 2'd2, 8'h00, 1'b0, 1'b0);
    do_read("c_data_kept",    2'd0, 8'h81, 1'b0, 1'b0);

    // Ready pin synchronizer latency
    nand_rnb = 1'b1;
    for (int k = 0; k <= SYNC; k++) begin
      do_read($sformatf("d_rnb_k%0d", k), 2'd2, (k == SYNC) ? 8'h02 : 8'h00, 1'b0, 1'b0);
    end

    // Reset while in ISSUE
    cmd_ready = 1'b0;
    push_cmd(8'h55, 8'h81, 0, 1'b1);
    do_write(2'd1, 8'h55);
    do_read("e_issue_status", 2'd2, 8'h03, 1'b0, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    do_read("e_post_rst_status", 2'd2, 8'h00, 1'b0, 1'b0);
    do_read("e_post_rst_cmd",    2'd1, 8'h00, 1'b0, 1'b0);
    done_pulse(8'hEE);
    do_read("e_done_ignored",    2'd0, 8'h00, 1'b0, 1'b0);

    tick();
    end_req = 1'b1;
    tick();
    tick();
  end

endmodule
